// File: rtl/filter_sched_pkg.sv
// filter_sched_pkg: shared types and constants for the filter scheduler
package filter_sched_pkg;
  typedef enum logic {ST_STABLE, ST_PENDING} state_t;
  localparam int FILTER_W = 2;
  localparam logic MODE_AUTO = 1'b0;
  localparam logic MODE_MANUAL = 1'b1;
  localparam logic [FILTER_W-1:0] FREQ_QUIET = 2'd0;
  localparam logic [FILTER_W-1:0] FREQ_LOW = 2'd1;
  localparam logic [FILTER_W-1:0] FREQ_MID = 2'd2;
  localparam logic [FILTER_W-1:0] FREQ_HIGH = 2'd3;
endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-FF synchroniser, stability filter and press pulse for an active-low key
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic s1, s2, level, level_d;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      level <= 1'b1;
      level_d <= 1'b1;
      cnt <= '0;
    end else begin
      s1 <= key_n;
      s2 <= s1;
      level_d <= level;
      cnt <= (s2 == level) ? '0 : (cnt == CW'(DEBOUNCE_CYCLES) ? cnt : cnt + 1'b1);
      if (s2 != level && cnt == CW'(DEBOUNCE_CYCLES - 1)) level <= s2;
    end
  end
  assign press = level_d & ~level;
endmodule

// File: rtl/filter_sched_ctrl.sv
// filter_sched_ctrl: frame-aligned, hysteresis-filtered selection of the active video filter
module filter_sched_ctrl
  import filter_sched_pkg::*;
#(
  parameter int HOLD_FRAMES = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int NUM_FILTERS = 4
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  input  logic [FILTER_W-1:0] freq_flag,
  input  logic                mode_sw,
  input  logic                key_next_n,
  input  logic                vga_VS,
  output logic [FILTER_W-1:0] filter_num,
  output logic                filter_changed,
  output logic                pending
);
  localparam int CW = $clog2(HOLD_FRAMES + 1);
  state_t state, state_nx;
  logic vs1, vs2, vs3, frame_tick, press, mode_d, manual, mode_rise;
  logic diff, same_cand, last, commit, load, adv;
  logic [FILTER_W-1:0] man_sel, cand, target;
  logic [CW-1:0] frame_cnt;
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
    .clk(clk_clk),
    .rst(reset_reset),
    .key_n(key_next_n),
    .press(press)
  );
  assign manual = mode_sw == MODE_MANUAL;
  assign frame_tick = vs3 & ~vs2;
  assign mode_rise = manual & ~mode_d;
  assign target = manual ? (mode_rise ? filter_num : man_sel)
                : (int'(freq_flag) >= NUM_FILTERS ? FILTER_W'(NUM_FILTERS - 1) : freq_flag);
  assign diff = target != filter_num;
  assign same_cand = target == cand;
  assign last = int'(frame_cnt) >= (manual ? 1 : HOLD_FRAMES) - 1;
  assign commit = state == ST_PENDING && diff && same_cand && frame_tick && last;
  assign adv = state == ST_PENDING && diff && same_cand && frame_tick && !last;
  assign load = diff && (state == ST_STABLE || !same_cand);
  always_ff @(posedge clk_clk) begin
    if (reset_reset) state <= ST_STABLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = (state == ST_STABLE) ? (diff ? ST_PENDING : ST_STABLE)
             : ((!diff || commit) ? ST_STABLE : ST_PENDING);
  end
  always_comb begin
    pending = state == ST_PENDING;
  end
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      vs1 <= 1'b1;
      vs2 <= 1'b1;
      vs3 <= 1'b1;
      mode_d <= MODE_AUTO;
      man_sel <= '0;
      cand <= '0;
      frame_cnt <= '0;
      filter_num <= '0;
      filter_changed <= 1'b0;
    end else begin
      vs1 <= vga_VS;
      vs2 <= vs1;
      vs3 <= vs2;
      mode_d <= mode_sw;
      filter_changed <= commit;
      if (commit) filter_num <= cand;
      if (mode_rise) man_sel <= filter_num;
      else if (press && manual) man_sel <= (man_sel == FILTER_W'(NUM_FILTERS - 1)) ? '0 : man_sel + 1'b1;
      if (load) begin
        cand <= target;
        frame_cnt <= '0;
      end else if (adv) frame_cnt <= frame_cnt + 1'b1;
      else if (commit) frame_cnt <= '0;
    end
  end
endmodule

// File: tb/tb_filter_sched_ctrl.sv
// tb_filter_sched_ctrl: scenario and randomized checks of filter_sched_ctrl against a frame-level model
module tb_filter_sched_ctrl;
  localparam int HOLD = 4;
  logic clk = 1'b0, rst = 1'b1, mode = 1'b0, key = 1'b1, vs = 1'b1;
  logic [1:0] freq = 2'd0;
  logic [1:0] filter_num;
  logic filter_changed, pending;
  int checks = 0, errors = 0, pulses = 0;
  filter_sched_ctrl #(.HOLD_FRAMES(HOLD), .DEBOUNCE_CYCLES(8), .NUM_FILTERS(4)) dut (
    .clk_clk(clk),
    .reset_reset(rst),
    .freq_flag(freq),
    .mode_sw(mode),
    .key_next_n(key),
    .vga_VS(vs),
    .filter_num(filter_num),
    .filter_changed(filter_changed),
    .pending(pending)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (filter_changed === 1'b1) pulses++;
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic frame();
    cyc(100);
    vs = 1'b0;
    cyc(10);
    vs = 1'b1;
    cyc(90);
  endtask
  task automatic press_key(input int hold);
    for (int i = 0; i < 5; i++) begin key = ~key; cyc(1); end
    key = 1'b0;
    cyc(hold);
    for (int i = 0; i < 5; i++) begin key = ~key; cyc(1); end
    key = 1'b1;
    cyc(30);
  endtask
  task automatic test_reset();
    rst = 1'b1; freq = 2'd2; mode = 1'b0; key = 1'b1; vs = 1'b1;
    cyc(3);
    checks++; if (filter_num !== 2'd0) begin errors++; $display("FAIL rst_num got %0d want 0", filter_num); end
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL rst_pending got %0b want 0", pending); end
    checks++; if (filter_changed !== 1'b0) begin errors++; $display("FAIL rst_changed got %0b want 0", filter_changed); end
    rst = 1'b0;
    cyc(1);
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL post_rst_pending got %0b want 1", pending); end
    checks++; if (filter_num !== 2'd0) begin errors++; $display("FAIL post_rst_num got %0d want 0", filter_num); end
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      frame();
      checks++; if (filter_num !== 2'd0) begin errors++; $display("FAIL hold_num frame %0d got %0d want 0", i, filter_num); end
    end
    cyc(100);
    vs = 1'b0;
    cyc(2);
    checks++; if (filter_num !== 2'd0) begin errors++; $display("FAIL pre_commit_num got %0d want 0", filter_num); end
    cyc(1);
    checks++; if (filter_num !== 2'd2) begin errors++; $display("FAIL commit_num got %0d want 2", filter_num); end
    checks++; if (filter_changed !== 1'b1) begin errors++; $display("FAIL commit_pulse got %0b want 1", filter_changed); end
    cyc(1);
    checks++; if (filter_changed !== 1'b0) begin errors++; $display("FAIL pulse_width got %0b want 0", filter_changed); end
    cyc(6);
    vs = 1'b1;
    cyc(90);
    checks++; if (pulses !== 1) begin errors++; $display("FAIL reset_pulses got %0d want 1", pulses); end
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL reset_settled got %0b want 0", pending); end
  endtask
  task automatic test_restart();
    freq = 2'd0;
    repeat (4) frame();
    checks++; if (filter_num !== 2'd0) begin errors++; $display("FAIL restart_setup got %0d want 0", filter_num); end
    pulses = 0;
    freq = 2'd1;
    for (int i = 0; i < 2; i++) begin
      frame();
      checks++; if (filter_num !== 2'd0) begin errors++; $display("FAIL restart_first got %0d want 0", filter_num); end
    end
    freq = 2'd3;
    for (int i = 0; i < 3; i++) begin
      frame();
      checks++; if (filter_num !== 2'd0) begin errors++; $display("FAIL restart_wait frame %0d got %0d want 0", i, filter_num); end
    end
    frame();
    checks++; if (filter_num !== 2'd3) begin errors++; $display("FAIL restart_commit got %0d want 3", filter_num); end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL restart_pulses got %0d want 1", pulses); end
  endtask
  task automatic test_withdraw();
    freq = 2'd0;
    repeat (4) frame();
    checks++; if (filter_num !== 2'd0) begin errors++; $display("FAIL withdraw_setup got %0d want 0", filter_num); end
    pulses = 0;
    freq = 2'd2;
    repeat (2) frame();
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL withdraw_pending got %0b want 1", pending); end
    freq = 2'd0;
    cyc(3);
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL withdraw_drop got %0b want 0", pending); end
    repeat (3) frame();
    checks++; if (filter_num !== 2'd0) begin errors++; $display("FAIL withdraw_num got %0d want 0", filter_num); end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL withdraw_pulses got %0d want 0", pulses); end
  endtask
  task automatic test_manual();
    int exp_sel, prev;
    freq = 2'd2;
    repeat (4) frame();
    checks++; if (filter_num !== 2'd2) begin errors++; $display("FAIL manual_setup got %0d want 2", filter_num); end
    pulses = 0;
    freq = 2'd0;
    mode = 1'b1;
    cyc(3);
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL manual_entry_pending got %0b want 0", pending); end
    checks++; if (filter_num !== 2'd2) begin errors++; $display("FAIL manual_entry_num got %0d want 2", filter_num); end
    exp_sel = 2;
    for (int k = 0; k < 3; k++) begin
      prev = exp_sel;
      exp_sel = (exp_sel + 1) % 4;
      press_key(30);
      checks++; if (filter_num !== 2'(prev)) begin errors++; $display("FAIL manual_pre_tick %0d got %0d want %0d", k, filter_num, prev); end
      checks++; if (pending !== 1'b1) begin errors++; $display("FAIL manual_pending %0d got %0b want 1", k, pending); end
      frame();
      checks++; if (filter_num !== 2'(exp_sel)) begin errors++; $display("FAIL manual_commit %0d got %0d want %0d", k, filter_num, exp_sel); end
    end
    checks++; if (pulses !== 3) begin errors++; $display("FAIL manual_pulses got %0d want 3", pulses); end
  endtask
  task automatic test_hold();
    pulses = 0;
    press_key(1000);
    frame();
    checks++; if (filter_num !== 2'd2) begin errors++; $display("FAIL held_key_num got %0d want 2", filter_num); end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL held_key_pulses got %0d want 1", pulses); end
    mode = 1'b0;
    freq = 2'd2;
    cyc(5);
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL auto_entry_pending got %0b want 0", pending); end
    press_key(1000);
    repeat (2) frame();
    checks++; if (filter_num !== 2'd2) begin errors++; $display("FAIL auto_press_num got %0d want 2", filter_num); end
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL auto_press_pending got %0b want 0", pending); end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL auto_press_pulses got %0d want 1", pulses); end
  endtask
  task automatic test_reset_mid();
    freq = 2'd1;
    repeat (2) frame();
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL mid_pending got %0b want 1", pending); end
    checks++; if (filter_num !== 2'd2) begin errors++; $display("FAIL mid_num got %0d want 2", filter_num); end
    pulses = 0;
    rst = 1'b1;
    cyc(1);
    checks++; if (filter_num !== 2'd0) begin errors++; $display("FAIL mid_rst_num got %0d want 0", filter_num); end
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL mid_rst_pending got %0b want 0", pending); end
    rst = 1'b0;
    cyc(1);
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL mid_resume_pending got %0b want 1", pending); end
    repeat (3) frame();
    checks++; if (filter_num !== 2'd0) begin errors++; $display("FAIL mid_fresh_count got %0d want 0", filter_num); end
    frame();
    checks++; if (filter_num !== 2'd1) begin errors++; $display("FAIL mid_commit got %0d want 1", filter_num); end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL mid_pulses got %0d want 1", pulses); end
  endtask
  task automatic test_random();
    int committed, cand, cnt, exp_pulses, t;
    bit pend;
    rst = 1'b1; mode = 1'b0; freq = 2'd0;
    cyc(2);
    rst = 1'b0;
    cyc(1);
    pulses = 0;
    committed = 0; cand = 0; cnt = 0; pend = 0; exp_pulses = 0; t = 0;
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(3) == 0) t = int'($urandom_range(3));
      freq = 2'(t);
      if (t == committed) pend = 0;
      else if (!pend || t != cand) begin pend = 1; cand = t; cnt = 0; end
      frame();
      if (pend) begin
        cnt++;
        if (cnt == HOLD) begin committed = cand; pend = 0; exp_pulses++; end
      end
      checks++; if (filter_num !== 2'(committed)) begin errors++; $display("FAIL rand_num frame %0d got %0d want %0d", f, filter_num, committed); end
      checks++; if (pending !== pend) begin errors++; $display("FAIL rand_pending frame %0d got %0b want %0b", f, pending, pend); end
    end
    checks++; if (pulses !== exp_pulses) begin errors++; $display("FAIL rand_pulses got %0d want %0d", pulses, exp_pulses); end
  endtask
  initial begin
    test_reset();
    test_restart();
    test_withdraw();
    test_manual();
    test_hold();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
